mipi_csi_rx_frame_ctrl: RTL and testbench
=========================================

Name: mipi_csi_rx_frame_ctrl

Overview:
Sequencing controller after mipi_csi_rx_packet_decoder_8b2lane. Consumes the decoder's packet stream (valid, 16-bit words, length, 3-bit type) and builds frame/line framing for the downstream pixel path. Counts payload words against the header length and lines per frame, flags protocol errors, and re-arms the decoder after every packet or error.

Parameters:
TIMEOUT_CYCLES, 4096, idle cycles inside a frame before forced abort
MAX_LINES, 4095, lines per frame before overflow error
LINE_CNT_W, 12, width of line counter
FRAME_CNT_W, 16, width of frame counter

Ports:
clk_i  in  1  byte clock, same domain as decoder
reset_n_i  in  1  asynchronous active-low reset
pkt_valid_i  in  1  decoder output_valid_o
pkt_data_i  in  16  decoder data_o, two payload bytes per cycle, little byte first
pkt_length_i  in  16  decoder packet_length_o in bytes, stable while pkt_valid_i high
pkt_type_i  in  3  decoder packet_type_o
dec_rst_n_o  out  1  active-low re-arm pulse to decoder sync logic
frame_valid_o  out  1  high from FS to FE
line_valid_o  out  1  high during payload beats of a long packet
data_o  out  16  registered payload word
data_valid_o  out  1  qualifies data_o
byte_en_o  out  2  bit0 low byte, bit1 high byte valid
line_count_o  out  LINE_CNT_W  lines completed in current frame
frame_count_o  out  FRAME_CNT_W  frames completed, wraps
err_o  out  4  sticky until next FS: [0] short line, [1] long line, [2] timeout, [3] line overflow/unexpected packet

Behaviour:
- Reset (async, reset_n_i low): all outputs 0 except dec_rst_n_o = 0 while reset is asserted and for 1 cycle after release. State IDLE.
- Type encoding: 0 FS, 1 FE, 2 LS, 3 LE, 4..7 long (payload) packet. Short packets present pkt_valid_i for exactly 1 cycle. Long packets hold pkt_valid_i for ceil(len/2) consecutive cycles; the first high cycle after low marks start.
- States: IDLE, FRAME, LINE, ABORT.
- IDLE: FS -> FRAME, frame_valid_o=1 next cycle, line_count_o=0, err_o cleared. All other packets ignored and re-armed.
- FRAME: long start -> LINE, words_left = ceil(len/2). FE -> IDLE, frame_valid_o=0, frame_count_o+1, wraps at 2^FRAME_CNT_W. LS/LE accepted, no effect. FS -> err[3], counters restarted, stay FRAME. Idle counter reaching TIMEOUT_CYCLES -> err[2], ABORT.
- LINE: each valid beat -> data_o/data_valid_o/line_valid_o one cycle later (1-cycle latency). Last beat with odd len -> byte_en_o=01, else 11. Decrement words_left. Reaching 0 while valid still high -> err[1], extra beats dropped. Valid low with words_left>0 -> err[0]. Either end -> line_count_o+1 (saturate at MAX_LINES, err[3] if exceeded), back to FRAME.
- len=0 long packet: no beats emitted, line counted, no error.
- dec_rst_n_o: pulsed low 1 cycle after every packet end (valid falling edge) and on entry to ABORT.
- ABORT: frame_valid_o=0, line_valid_o=0, hold 2 cycles with dec_rst_n_o=0, then IDLE. frame_count_o not incremented.
- Simultaneous timeout and valid: valid wins, timeout counter cleared.
- Reset mid-frame: immediate clear, no partial outputs.

Decomposition:
- Package mipi_csi_rx_pkg: packet type constants (PKT_FS, PKT_FE, PKT_LS, PKT_LE, PKT_LONG_MIN), state encoding, error bit indices.
- One sub-module mipi_csi_rx_payload_counter: words_left load/decrement, byte_en generation, short/long error detection.

Test Plan:
- FS, long type 4 len=8 (4 beats 0x0000,0x1000,0x2000,0x3000), FE -> frame_valid 1 then 0, 4 data_valid beats at 1-cycle latency, byte_en=11, line_count=1, frame_count=1, err=0.
- Long len=7 -> 4 beats, last byte_en=01, no error.
- Long len=8 with 6 beats -> 4 emitted, err[1]=1. Len=8 with 2 beats -> err[0]=1, line still counted.
- FS then silence TIMEOUT_CYCLES -> err[2], dec_rst_n_o low 2 cycles, frame_valid 0, frame_count unchanged, next FS clears err.
- Packets before FS (LS, long) -> ignored, no data_valid, dec_rst_n_o pulses after each.
- reset_n_i low mid-payload -> all outputs 0 asynchronously, dec_rst_n_o low until 1 cycle after release.

Source files
------------

// File: rtl/mipi_csi_rx_pkg.sv
// Shared constants for the CSI-2 receive frame controller: packet type codes,
// controller state encoding and error flag bit positions.
package mipi_csi_rx_pkg;

    localparam logic [2:0] PKT_FS       = 3'd0;
    localparam logic [2:0] PKT_FE       = 3'd1;
    localparam logic [2:0] PKT_LS       = 3'd2;
    localparam logic [2:0] PKT_LE       = 3'd3;
    localparam logic [2:0] PKT_LONG_MIN = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_LINE  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    localparam int ERR_SHORT   = 0;
    localparam int ERR_LONG    = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVF     = 3;

    // Number of 16-bit beats carrying a payload of len bytes (rounded up).
    function automatic logic [15:0] len_to_words(input logic [15:0] len);
        return (len >> 1) + {15'd0, len[0]};
    endfunction

endpackage

// File: rtl/mipi_csi_rx_payload_counter.sv
// Tracks the remaining payload words of one long packet. The start beat is
// consumed in the same cycle as the load, so the stored count excludes it.
module mipi_csi_rx_payload_counter
    import mipi_csi_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        load_i,
    input  logic        active_i,
    input  logic        valid_i,
    input  logic [15:0] len_i,
    output logic        beat_o,
    output logic [1:0]  byte_en_o,
    output logic        line_done_o,
    output logic        err_short_o,
    output logic        err_long_o
);

    logic [15:0] words_left_q, words_left_d;
    logic        odd_q, odd_d;
    logic [15:0] total;

    // Load on packet start, count down on each beat, flag early or late end.
    always_comb begin
        total        = len_to_words(len_i);
        words_left_d = words_left_q;
        odd_d        = odd_q;
        beat_o       = 1'b0;
        byte_en_o    = 2'b11;
        line_done_o  = 1'b0;
        err_short_o  = 1'b0;
        err_long_o   = 1'b0;
        if (load_i) begin
            odd_d = len_i[0];
            if (total == 16'd0) begin
                line_done_o  = 1'b1;
                words_left_d = 16'd0;
            end else begin
                beat_o       = 1'b1;
                words_left_d = total - 16'd1;
                if (total == 16'd1 && len_i[0]) byte_en_o = 2'b01;
            end
        end else if (active_i) begin
            if (!valid_i) begin
                line_done_o = 1'b1;
                err_short_o = (words_left_q != 16'd0);
            end else if (words_left_q == 16'd0) begin
                line_done_o = 1'b1;
                err_long_o  = 1'b1;
            end else begin
                beat_o       = 1'b1;
                words_left_d = words_left_q - 16'd1;
                if (words_left_q == 16'd1 && odd_q) byte_en_o = 2'b01;
            end
        end
    end

    // Remaining-word register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            words_left_q <= 16'd0;
            odd_q        <= 1'b0;
        end else begin
            words_left_q <= words_left_d;
            odd_q        <= odd_d;
        end
    end

endmodule

// File: rtl/mipi_csi_rx_frame_ctrl.sv
// Frame/line sequencing after the CSI-2 packet decoder.
//   state    | meaning
//   IDLE     | waiting for frame start, other packets ignored
//   FRAME    | inside a frame, between lines; idle timer running
//   LINE     | forwarding payload beats of a long packet
//   ABORT    | timeout recovery, decoder held in re-arm for 2 cycles
module mipi_csi_rx_frame_ctrl
    import mipi_csi_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_LINES      = 4095,
    parameter int LINE_CNT_W     = 12,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   pkt_valid_i,
    input  logic [15:0]            pkt_data_i,
    input  logic [15:0]            pkt_length_i,
    input  logic [2:0]             pkt_type_i,
    output logic                   dec_rst_n_o,
    output logic                   frame_valid_o,
    output logic                   line_valid_o,
    output logic [15:0]            data_o,
    output logic                   data_valid_o,
    output logic [1:0]             byte_en_o,
    output logic [LINE_CNT_W-1:0]  line_count_o,
    output logic [FRAME_CNT_W-1:0] frame_count_o,
    output logic [3:0]             err_o
);

    localparam int                    TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]      TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX = LINE_CNT_W'(MAX_LINES);

    logic [1:0]             state_q, state_d;
    logic                   valid_prev_q;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   abort_tmr_q, abort_tmr_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [LINE_CNT_W-1:0]  line_count_q, line_count_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [3:0]             err_q, err_d;
    logic [15:0]            data_q;
    logic                   data_valid_q;
    logic [1:0]             byte_en_q;
    logic                   dec_arm_q, dec_rst_n_q, dec_rst_n_d;

    logic       pkt_start, pkt_end, is_long, timeout, line_inc;
    logic       pc_beat, pc_line_done, pc_err_short, pc_err_long;
    logic [1:0] pc_byte_en;

    assign pkt_start = pkt_valid_i & ~valid_prev_q;
    assign pkt_end   = ~pkt_valid_i & valid_prev_q;
    assign is_long   = (pkt_type_i >= PKT_LONG_MIN);
    assign timeout   = (state_q == ST_FRAME) && !pkt_valid_i && (tmr_q == '0);

    mipi_csi_rx_payload_counter u_payload_counter (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_i      ((state_q == ST_FRAME) && pkt_start && is_long),
        .active_i    (state_q == ST_LINE),
        .valid_i     (pkt_valid_i),
        .len_i       (pkt_length_i),
        .beat_o      (pc_beat),
        .byte_en_o   (pc_byte_en),
        .line_done_o (pc_line_done),
        .err_short_o (pc_err_short),
        .err_long_o  (pc_err_long)
    );

    // Next-state, framing counters and sticky error flags.
    always_comb begin
        state_d       = state_q;
        abort_tmr_d   = abort_tmr_q;
        frame_valid_d = frame_valid_q;
        line_count_d  = line_count_q;
        frame_count_d = frame_count_q;
        err_d         = err_q;
        line_inc      = 1'b0;
        // Any valid beat (including one coinciding with expiry) restarts the idle timer.
        if (state_q != ST_FRAME || pkt_valid_i) tmr_d = TMR_LOAD;
        else if (tmr_q != '0)                    tmr_d = tmr_q - 1'b1;
        else                                     tmr_d = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_start && pkt_type_i == PKT_FS) begin
                    state_d       = ST_FRAME;
                    frame_valid_d = 1'b1;
                    line_count_d  = '0;
                    err_d         = '0;
                end
            end
            ST_FRAME: begin
                if (pkt_start) begin
                    if (is_long) begin
                        line_inc = pc_line_done;
                        if (!pc_line_done) state_d = ST_LINE;
                    end else if (pkt_type_i == PKT_FE) begin
                        state_d       = ST_IDLE;
                        frame_valid_d = 1'b0;
                        frame_count_d = frame_count_q + 1'b1;
                    end else if (pkt_type_i == PKT_FS) begin
                        err_d[ERR_OVF] = 1'b1;
                        line_count_d   = '0;
                    end
                end else if (timeout) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_ABORT;
                    frame_valid_d      = 1'b0;
                    abort_tmr_d        = 1'b1;
                end
            end
            ST_LINE: begin
                if (pc_line_done) begin
                    line_inc = 1'b1;
                    state_d  = ST_FRAME;
                    if (pc_err_short) err_d[ERR_SHORT] = 1'b1;
                    if (pc_err_long)  err_d[ERR_LONG]  = 1'b1;
                end
            end
            ST_ABORT: begin
                if (abort_tmr_q == 1'b0) state_d = ST_IDLE;
                else                     abort_tmr_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (line_inc) begin
            if (line_count_q == LINE_MAX) err_d[ERR_OVF] = 1'b1;
            else                          line_count_d = line_count_q + 1'b1;
        end
        dec_rst_n_d = dec_arm_q & ~pkt_end & (state_d != ST_ABORT);
    end

    // State, counters and registered output stage.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            valid_prev_q  <= 1'b0;
            tmr_q         <= '0;
            abort_tmr_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            line_count_q  <= '0;
            frame_count_q <= '0;
            err_q         <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            byte_en_q     <= '0;
            dec_arm_q     <= 1'b0;
            dec_rst_n_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_prev_q  <= pkt_valid_i;
            tmr_q         <= tmr_d;
            abort_tmr_q   <= abort_tmr_d;
            frame_valid_q <= frame_valid_d;
            line_count_q  <= line_count_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
            data_q        <= pc_beat ? pkt_data_i : data_q;
            data_valid_q  <= pc_beat;
            byte_en_q     <= pc_beat ? pc_byte_en : 2'b00;
            dec_arm_q     <= 1'b1;
            dec_rst_n_q   <= dec_rst_n_d;
        end
    end

    assign dec_rst_n_o   = dec_rst_n_q;
    assign frame_valid_o = frame_valid_q;
    assign line_valid_o  = data_valid_q;
    assign data_o        = data_q;
    assign data_valid_o  = data_valid_q;
    assign byte_en_o     = byte_en_q;
    assign line_count_o  = line_count_q;
    assign frame_count_o = frame_count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mipi_csi_rx_frame_ctrl.sv
// Bench for the CSI-2 frame controller: table of single-line frames plus
// hand-written sequences for timeout, overflow, pre-FS traffic and reset.
module tb_mipi_csi_rx_frame_ctrl;

    localparam int T  = 32;
    localparam int ML = 3;
    localparam int LW = 12;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pkt_valid;
    logic [15:0]   pkt_data;
    logic [15:0]   pkt_len;
    logic [2:0]    pkt_type;
    logic          dec_rst_n;
    logic          frame_valid;
    logic          line_valid;
    logic [15:0]   data;
    logic          data_valid;
    logic [1:0]    byte_en;
    logic [LW-1:0] line_count;
    logic [FW-1:0] frame_count;
    logic [3:0]    err;

    always #5 clk = ~clk;

    mipi_csi_rx_frame_ctrl #(
        .TIMEOUT_CYCLES(T), .MAX_LINES(ML), .LINE_CNT_W(LW), .FRAME_CNT_W(FW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .pkt_valid_i(pkt_valid),
        .pkt_data_i(pkt_data), .pkt_length_i(pkt_len), .pkt_type_i(pkt_type),
        .dec_rst_n_o(dec_rst_n), .frame_valid_o(frame_valid),
        .line_valid_o(line_valid), .data_o(data), .data_valid_o(data_valid),
        .byte_en_o(byte_en), .line_count_o(line_count),
        .frame_count_o(frame_count), .err_o(err)
    );

    typedef struct { logic [15:0] data; logic [1:0] be; } beat_t;
    typedef struct { logic [2:0] t; logic [15:0] len; int nb; logic [3:0] err; } vec_t;

    beat_t         exp_q[$];
    vec_t          vecs[8];
    int            checks = 0;
    int            failures = 0;
    logic [FW-1:0] exp_fc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Output beats are checked against the scoreboard at each falling edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (reset_n && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", data, e.data);
                chk("beat_be", byte_en, e.be);
                chk("beat_line_valid", line_valid, 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pkt_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_short(input logic [2:0] t);
        pkt_valid = 1'b1; pkt_type = t; pkt_len = '0; pkt_data = '0;
        tick();
        pkt_valid = 1'b0;
        tick();
        chk("rearm_after_short", dec_rst_n, 0);
    endtask

    task automatic send_long(input logic [2:0] t, input logic [15:0] len, input int n,
                             input int tag, input bit in_frame);
        int words;
        beat_t b;
        words = (int'(len) + 1) / 2;
        for (int i = 0; i < n; i++) begin
            pkt_valid = 1'b1; pkt_type = t; pkt_len = len;
            pkt_data  = 16'(i << 12) | 16'(tag);
            if (in_frame && i < words) begin
                b.data = pkt_data;
                b.be   = (i == words - 1 && len[0]) ? 2'b01 : 2'b11;
                exp_q.push_back(b);
            end
            tick();
        end
        pkt_valid = 1'b0;
        tick();
        chk("rearm_after_long", dec_rst_n, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dec_rst_n"}, dec_rst_n, 0);
        chk({tag, "_frame_valid"}, frame_valid, 0);
        chk({tag, "_line_valid"}, line_valid, 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_byte_en"}, byte_en, 0);
        chk({tag, "_line_count"}, line_count, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{t: 3'd4, len: 16'd8, nb: 4, err: 4'b0000};
        vecs[1] = '{t: 3'd5, len: 16'd7, nb: 4, err: 4'b0000};
        vecs[2] = '{t: 3'd4, len: 16'd8, nb: 6, err: 4'b0010};
        vecs[3] = '{t: 3'd6, len: 16'd8, nb: 2, err: 4'b0001};
        vecs[4] = '{t: 3'd7, len: 16'd0, nb: 1, err: 4'b0000};
        vecs[5] = '{t: 3'd4, len: 16'd1, nb: 1, err: 4'b0000};
        vecs[6] = '{t: 3'd4, len: 16'd2, nb: 1, err: 4'b0000};
        vecs[7] = '{t: 3'd4, len: 16'd3, nb: 1, err: 4'b0001};

        reset_n = 1'b0; pkt_valid = 1'b0; pkt_data = '0; pkt_len = '0; pkt_type = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        #1 chk("release_dec_rst_n", dec_rst_n, 0);
        @(posedge clk); #1;
        chk("release_dec_rst_n_1", dec_rst_n, 0);
        tick();
        chk("release_dec_rst_n_2", dec_rst_n, 1);

        // Traffic before FS is ignored.
        send_short(3'd2);
        send_long(3'd4, 16'd4, 2, 0, 1'b0);
        chk("prefs_frame_valid", frame_valid, 0);
        chk("prefs_line_count", line_count, 0);

        // One line per frame, table driven.
        for (int v = 0; v < 8; v++) begin
            send_short(3'd0);
            chk("fs_frame_valid", frame_valid, 1);
            chk("fs_err_clear", err, 0);
            chk("fs_line_count", line_count, 0);
            send_long(vecs[v].t, vecs[v].len, vecs[v].nb, v, 1'b1);
            chk("vec_line_count", line_count, 1);
            send_short(3'd1);
            exp_fc++;
            chk("fe_frame_valid", frame_valid, 0);
            chk("vec_frame_count", frame_count, exp_fc);
            chk("vec_err", err, vecs[v].err);
            chk("vec_drain", exp_q.size(), 0);
        end

        // FS inside a frame.
        send_short(3'd0);
        send_short(3'd0);
        chk("dup_fs_err", err, 4'b1000);
        chk("dup_fs_frame_valid", frame_valid, 1);
        send_short(3'd1);
        exp_fc++;
        chk("dup_fs_frame_count", frame_count, exp_fc);

        // Line count saturation with LS/LE mixed in.
        send_short(3'd0);
        send_short(3'd2);
        for (int i = 0; i < ML; i++) send_long(3'd4, 16'd2, 1, 16 + i, 1'b1);
        chk("ovf_line_count_max", line_count, ML);
        chk("ovf_err_none", err, 0);
        send_short(3'd3);
        send_long(3'd4, 16'd2, 1, 32, 1'b1);
        chk("ovf_line_count_sat", line_count, ML);
        chk("ovf_err", err, 4'b1000);
        send_short(3'd1);
        exp_fc++;
        chk("ovf_frame_count", frame_count, exp_fc);

        // Valid arriving on the expiry cycle wins over the timeout.
        send_short(3'd0);
        idle(T - 2);
        send_long(3'd4, 16'd4, 2, 48, 1'b1);
        chk("tmo_race_err", err, 0);
        chk("tmo_race_frame_valid", frame_valid, 1);
        chk("tmo_race_line_count", line_count, 1);
        send_short(3'd1);
        exp_fc++;

        // Timeout abort.
        send_short(3'd0);
        idle(T - 2);
        chk("tmo_pre_err", err, 0);
        chk("tmo_pre_frame_valid", frame_valid, 1);
        tick();
        chk("tmo_err", err, 4'b0100);
        chk("tmo_frame_valid", frame_valid, 0);
        chk("tmo_dec_rst_0", dec_rst_n, 0);
        tick();
        chk("tmo_dec_rst_1", dec_rst_n, 0);
        tick();
        chk("tmo_dec_rst_2", dec_rst_n, 1);
        chk("tmo_frame_count", frame_count, exp_fc);
        send_short(3'd0);
        chk("tmo_next_fs_err", err, 0);
        chk("tmo_next_fs_frame_valid", frame_valid, 1);
        send_short(3'd1);
        exp_fc++;
        chk("tmo_next_frame_count", frame_count, exp_fc);

        // Reset in the middle of a payload.
        send_short(3'd0);
        pkt_valid = 1'b1; pkt_type = 3'd4; pkt_len = 16'd8; pkt_data = 16'hABCD;
        @(posedge clk); #1;
        chk("midrst_pre_data_valid", data_valid, 1);
        #1 reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        pkt_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("midrst_dec_rst_n", dec_rst_n, 0);
        @(posedge clk); #1;
        chk("midrst_dec_rst_n_1", dec_rst_n, 0);
        tick();
        chk("midrst_dec_rst_n_2", dec_rst_n, 1);
        exp_fc = '0;

        // Normal frame after reset recovery.
        send_short(3'd0);
        send_long(3'd5, 16'd3, 2, 64, 1'b1);
        send_short(3'd1);
        exp_fc++;
        chk("post_rst_frame_count", frame_count, exp_fc);
        chk("post_rst_line_count", line_count, 1);
        chk("post_rst_err", err, 0);
        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
